audio_frame_serializer: RTL and testbench

Parametrised stereo serial transmitter for the WM8731 DAC path. It accepts left/right sample pairs over a valid/ready handshake and serializes them MSB-first onto DACDAT. It generates DACLRC in one of four codec formats: I2S, left-justified, right-justified or DSP. It runs in the system clock domain and advances one bit per `bit_en` strobe, which marks a BCLK falling edge.

---
 rtl/audio_pkg.sv | 12 +
 rtl/audio_shift_lane.sv | 28 ++
 rtl/audio_frame_serializer.sv | 170 +++++++++++++++++
 tb/tb_audio_frame_serializer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants for the WM8731 DAC-path serializer: codec format codes and FSM states.
package audio_pkg;

    localparam logic [1:0] FMT_I2S  = 2'd0;
    localparam logic [1:0] FMT_LJ   = 2'd1;
    localparam logic [1:0] FMT_RJ   = 2'd2;
    localparam logic [1:0] FMT_DSPA = 2'd3;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

endpackage

// File: rtl/audio_shift_lane.sv
// One channel's MSB-first shifter. A load with shift asserted stores the word already
// advanced by one bit, for formats whose first data bit is issued on the load strobe.
module audio_shift_lane #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= shift ? {din[WIDTH-2:0], 1'b0} : din;
        end else if (shift) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sr[WIDTH-1];

endmodule

// File: rtl/audio_frame_serializer.sv
// Stereo serial transmitter for the WM8731 DAC: holding register, frame bit counter,
// IDLE/RUN FSM and per-format data-window decode driving DACDAT/DACLRC.
module audio_frame_serializer
    import audio_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int SLOT  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_en,
    input  logic             run,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] left_in,
    input  logic [WIDTH-1:0] right_in,
    input  logic             valid,
    output logic             ready,
    output logic             dacdat,
    output logic             daclrc,
    output logic             frame_start,
    output logic             underrun
);

    localparam int CW = $clog2(2 * SLOT);
    localparam logic [CW-1:0] LAST = CW'(2 * SLOT - 1);

    logic [0:0]       state;
    logic [CW-1:0]    bit_idx;
    logic [1:0]       cur_mode;
    logic [WIDTH-1:0] hold_l;
    logic [WIDTH-1:0] hold_r;
    logic             full;

    logic             wrap;
    logic             start;
    logic             stop;
    logic             adv;
    logic [CW-1:0]    n_next;
    logic [1:0]       m_next;
    logic [WIDTH-1:0] load_l;
    logic [WIDTH-1:0] load_r;
    logic             msb_l;
    logic             msb_r;
    logic             shift_l;
    logic             shift_r;
    logic             dacdat_next;

    int               n_int;
    int               k;
    logic             ch;
    logic             win_data;
    logic             win_ch;
    logic             win_lrc;

    // A transfer happens on any clk edge where valid && ready; ready is simply !full,
    // and the held pair is only ever consumed by a frame-start strobe.
    assign ready = !full;

    assign wrap   = (bit_idx == LAST);
    assign start  = bit_en && run && ((state == IDLE) || wrap);
    assign stop   = bit_en && (state == RUN) && wrap && !run;
    assign adv    = bit_en && (state == RUN) && !wrap;
    assign n_next = start ? '0 : bit_idx + 1'b1;
    assign m_next = start ? mode : cur_mode;
    assign load_l = full ? hold_l : '0;
    assign load_r = full ? hold_r : '0;

    always_comb begin
        n_int    = int'(n_next);
        ch       = (n_int >= SLOT);
        k        = ch ? n_int - SLOT : n_int;
        win_data = 1'b0;
        win_ch   = ch;
        win_lrc  = 1'b0;
        case (m_next)
            FMT_I2S: begin
                win_lrc  = ch;
                win_data = (k >= 1) && (k <= WIDTH);
            end
            FMT_LJ: begin
                win_lrc  = !ch;
                win_data = (k < WIDTH);
            end
            FMT_RJ: begin
                win_lrc  = !ch;
                win_data = (k >= SLOT - WIDTH);
            end
            default: begin
                win_lrc  = (n_int == 0);
                win_data = (n_int >= 1) && (n_int <= 2 * WIDTH);
                win_ch   = (n_int > WIDTH);
            end
        endcase
    end

    // On the frame-start strobe the shifters are only being loaded, so bit 0 comes from the load value.
    always_comb begin
        shift_l = (start || adv) && win_data && !win_ch;
        shift_r = (start || adv) && win_data && win_ch;
        if (start) begin
            dacdat_next = win_data && load_l[WIDTH-1];
        end else begin
            dacdat_next = win_data && (win_ch ? msb_r : msb_l);
        end
    end

    audio_shift_lane #(.WIDTH(WIDTH)) u_lane_l (
        .clk   (clk),
        .reset (reset),
        .load  (start),
        .shift (shift_l),
        .din   (load_l),
        .msb   (msb_l)
    );

    audio_shift_lane #(.WIDTH(WIDTH)) u_lane_r (
        .clk   (clk),
        .reset (reset),
        .load  (start),
        .shift (shift_r),
        .din   (load_r),
        .msb   (msb_r)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_idx     <= '0;
            cur_mode    <= FMT_I2S;
            hold_l      <= '0;
            hold_r      <= '0;
            full        <= 1'b0;
            dacdat      <= 1'b0;
            daclrc      <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (valid && !full) begin
                hold_l <= left_in;
                hold_r <= right_in;
                full   <= 1'b1;
            end
            if (start) begin
                state       <= RUN;
                bit_idx     <= '0;
                cur_mode    <= mode;
                frame_start <= 1'b1;
                if (full) begin
                    full <= 1'b0;
                end else begin
                    underrun <= 1'b1;
                end
                dacdat <= dacdat_next;
                daclrc <= win_lrc;
            end else if (stop) begin
                state   <= IDLE;
                bit_idx <= '0;
                dacdat  <= 1'b0;
                daclrc  <= 1'b0;
            end else if (adv) begin
                bit_idx <= bit_idx + 1'b1;
                dacdat  <= dacdat_next;
                daclrc  <= win_lrc;
            end
        end
    end

endmodule

// File: tb/tb_audio_frame_serializer.sv
// Directed bench: a 24-bit instance for the format/underrun/mode/reset cases and a 16-bit instance for right-justified.
module tb_audio_frame_serializer;

    localparam logic [1:0] M_I2S  = 2'd0;
    localparam logic [1:0] M_LJ   = 2'd1;
    localparam logic [1:0] M_RJ   = 2'd2;
    localparam logic [1:0] M_DSPA = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bit_en = 1'b0;
    logic        run_a = 1'b0;
    logic        run_b = 1'b0;
    logic [1:0]  mode = M_I2S;
    logic [23:0] left_a = '0;
    logic [23:0] right_a = '0;
    logic        valid_a = 1'b0;
    logic [15:0] left_b = '0;
    logic [15:0] right_b = '0;
    logic        valid_b = 1'b0;

    logic ready_a, dacdat_a, daclrc_a, frame_start_a, underrun_a;
    logic ready_b, dacdat_b, daclrc_b, frame_start_b, underrun_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] cap_a_dat, cap_a_lrc, cap_b_dat, cap_b_lrc;
    int          fs_a, ur_a;
    logic        acc;

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic [23:0] l;
        logic [23:0] r;
        logic [63:0] dat;
        logic [63:0] lrc;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    audio_frame_serializer #(.WIDTH(24), .SLOT(32)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .bit_en      (bit_en),
        .run         (run_a),
        .mode        (mode),
        .left_in     (left_a),
        .right_in    (right_a),
        .valid       (valid_a),
        .ready       (ready_a),
        .dacdat      (dacdat_a),
        .daclrc      (daclrc_a),
        .frame_start (frame_start_a),
        .underrun    (underrun_a)
    );

    audio_frame_serializer #(.WIDTH(16), .SLOT(32)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .bit_en      (bit_en),
        .run         (run_b),
        .mode        (mode),
        .left_in     (left_b),
        .right_in    (right_b),
        .valid       (valid_b),
        .ready       (ready_b),
        .dacdat      (dacdat_b),
        .daclrc      (daclrc_b),
        .frame_start (frame_start_b),
        .underrun    (underrun_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bit_en strobe; returns at the negedge right after the strobe edge.
    task automatic tick();
        @(negedge clk);
        bit_en = 1'b1;
        @(negedge clk);
        bit_en = 1'b0;
    endtask

    task automatic push_a(input logic [23:0] l, input logic [23:0] r);
        int cnt;
        cnt = 0;
        valid_a = 1'b1;
        left_a  = l;
        right_a = r;
        while (!ready_a && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) check("push_a_timeout", 64'(ready_a), 64'd1);
        @(negedge clk);
        valid_a = 1'b0;
    endtask

    task automatic push_b(input logic [15:0] l, input logic [15:0] r);
        int cnt;
        cnt = 0;
        valid_b = 1'b1;
        left_b  = l;
        right_b = r;
        while (!ready_b && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) check("push_b_timeout", 64'(ready_b), 64'd1);
        @(negedge clk);
        valid_b = 1'b0;
    endtask

    task automatic capture(input int sw_at, input logic [1:0] sw_mode);
        fs_a = 0;
        ur_a = 0;
        for (int n = 0; n < 64; n++) begin
            tick();
            cap_a_dat[63-n] = dacdat_a;
            cap_a_lrc[63-n] = daclrc_a;
            cap_b_dat[63-n] = dacdat_b;
            cap_b_lrc[63-n] = daclrc_b;
            fs_a += int'(frame_start_a);
            ur_a += int'(underrun_a);
            if (n == sw_at) mode = sw_mode;
        end
    endtask

    initial begin
        vecs[0] = '{"i2s",  M_I2S,  24'hA5A5A5, 24'h5A5A5A,
                    {1'b0, 24'hA5A5A5, 8'h00, 24'h5A5A5A, 7'h00}, {32'h0, 32'hFFFF_FFFF}};
        vecs[1] = '{"lj",   M_LJ,   24'hA5A5A5, 24'h5A5A5A,
                    {24'hA5A5A5, 8'h00, 24'h5A5A5A, 8'h00}, {32'hFFFF_FFFF, 32'h0}};
        vecs[2] = '{"rj24", M_RJ,   24'hA5A5A5, 24'h5A5A5A,
                    {8'h00, 24'hA5A5A5, 8'h00, 24'h5A5A5A}, {32'hFFFF_FFFF, 32'h0}};
        vecs[3] = '{"dspa", M_DSPA, 24'hFFFFFF, 24'h000001,
                    {1'b0, 24'hFFFFFF, 24'h000001, 15'h0}, {1'b1, 63'h0}};

        // Reset values while reset is held.
        #22;
        check("reset_a_outs", {59'h0, dacdat_a, daclrc_a, ready_a, frame_start_a, underrun_a}, 64'b00100);
        check("reset_b_outs", {59'h0, dacdat_b, daclrc_b, ready_b, frame_start_b, underrun_b}, 64'b00100);
        @(negedge clk);
        reset = 1'b1;

        // Idle with run low.
        acc = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            acc = acc | dacdat_a | daclrc_a | frame_start_a;
        end
        check("idle_outputs_zero", 64'(acc), 64'd0);

        // Table of back-to-back formatted frames.
        run_a = 1'b1;
        for (int v = 0; v < 4; v++) begin
            mode = vecs[v].mode;
            push_a(vecs[v].l, vecs[v].r);
            capture(-1, M_I2S);
            check({vecs[v].name, "_dat"}, cap_a_dat, vecs[v].dat);
            check({vecs[v].name, "_lrc"}, cap_a_lrc, vecs[v].lrc);
            check({vecs[v].name, "_fs_count"}, 64'(fs_a), 64'd1);
            check({vecs[v].name, "_ur_count"}, 64'(ur_a), 64'd0);
        end

        // Underrun frame with nothing pending.
        mode = M_I2S;
        capture(-1, M_I2S);
        check("underrun_dat", cap_a_dat, 64'h0);
        check("underrun_count", 64'(ur_a), 64'd1);
        check("underrun_fs_count", 64'(fs_a), 64'd1);

        // Pair offered on the frame-start strobe itself.
        check("late_ready_before", 64'(ready_a), 64'd1);
        @(negedge clk);
        bit_en  = 1'b1;
        valid_a = 1'b1;
        left_a  = 24'h123456;
        right_a = 24'hFEDCBA;
        @(negedge clk);
        bit_en  = 1'b0;
        valid_a = 1'b0;
        check("late_underrun", 64'(underrun_a), 64'd1);
        check("late_frame_start", 64'(frame_start_a), 64'd1);
        check("late_ready_low", 64'(ready_a), 64'd0);
        acc = dacdat_a;
        for (int n = 1; n < 64; n++) begin
            tick();
            acc = acc | dacdat_a;
        end
        check("late_frame_zero", 64'(acc), 64'd0);
        capture(-1, M_I2S);
        check("late_next_dat", cap_a_dat, {1'b0, 24'h123456, 8'h00, 24'hFEDCBA, 7'h00});
        check("late_next_ur", 64'(ur_a), 64'd0);

        // Mode change I2S -> LJ mid-frame.
        mode = M_I2S;
        push_a(24'hA5A5A5, 24'h5A5A5A);
        capture(10, M_LJ);
        check("modesw_cur_dat", cap_a_dat, {1'b0, 24'hA5A5A5, 8'h00, 24'h5A5A5A, 7'h00});
        check("modesw_cur_lrc", cap_a_lrc, {32'h0, 32'hFFFF_FFFF});
        push_a(24'hA5A5A5, 24'h5A5A5A);
        capture(-1, M_LJ);
        check("modesw_next_dat", cap_a_dat, {24'hA5A5A5, 8'h00, 24'h5A5A5A, 8'h00});
        check("modesw_next_lrc", cap_a_lrc, {32'hFFFF_FFFF, 32'h0});

        // Right-justified on the 16-bit instance.
        mode = M_RJ;
        push_b(16'h8001, 16'h0000);
        run_b = 1'b1;
        capture(-1, M_RJ);
        check("rj16_dat", cap_b_dat, {16'h0, 16'h8001, 32'h0});
        check("rj16_lrc", cap_b_lrc, {32'hFFFF_FFFF, 32'h0});

        // Asynchronous reset mid-frame with a pair held.
        push_a(24'h777777, 24'h777777);
        for (int i = 0; i < 20; i++) tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_a_outs", {59'h0, dacdat_a, daclrc_a, ready_a, frame_start_a, underrun_a}, 64'b00100);
        check("midreset_b_outs", {59'h0, dacdat_b, daclrc_b, ready_b, frame_start_b, underrun_b}, 64'b00100);
        @(negedge clk);
        run_a = 1'b0;
        run_b = 1'b0;
        reset = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            acc = acc | dacdat_a | daclrc_a | dacdat_b | daclrc_b;
        end
        check("post_reset_idle_zero", 64'(acc), 64'd0);
        check("post_reset_ready", 64'(ready_a), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
